// File: rtl/booth_multiplier_seq_pkg.sv
// Shared types and constants for the sequential 4x4 Booth multiplier.
package booth_multiplier_seq_pkg;

    localparam int OP_WIDTH   = 4;
    localparam int ITERATIONS = 4;
    localparam int PROD_WIDTH = 2 * OP_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A Booth pair of 01 or 10 needs the add/sub result; 00 and 11 only shift.
    function automatic logic booth_uses_addsub(input logic q0, input logic q_1);
        return q0 ^ q_1;
    endfunction

endpackage

// File: rtl/booth_multiplier_seq_if.sv
// Operand/handshake bundle between a requester and the Booth multiplier.
interface booth_multiplier_seq_if;
    import booth_multiplier_seq_pkg::*;

    logic                  start;
    logic [OP_WIDTH-1:0]   multiplicand;
    logic [OP_WIDTH-1:0]   multiplier;
    logic                  busy;
    logic                  done;
    logic [PROD_WIDTH-1:0] product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );

endinterface

// File: rtl/booth_multiplier_seq_adder_subtractor.sv
// 4-bit two's complement adder/subtractor: sum = a + b (k=0) or a - b (k=1).
module adder_subtractor
    import booth_multiplier_seq_pkg::*;
(
    input  logic [OP_WIDTH-1:0] a,
    input  logic [OP_WIDTH-1:0] b,
    input  logic                k,
    output logic [OP_WIDTH-1:0] sum,
    output logic                overflow
);

    logic [OP_WIDTH-1:0] b_eff_s;

    // Invert b and inject a carry-in of 1 to subtract; overflow when the
    // operand signs agree but the result sign differs.
    always_comb begin
        b_eff_s  = b ^ {OP_WIDTH{k}};
        sum      = a + b_eff_s + {{(OP_WIDTH-1){1'b0}}, k};
        overflow = (a[OP_WIDTH-1] == b_eff_s[OP_WIDTH-1]) &&
                   (sum[OP_WIDTH-1] != a[OP_WIDTH-1]);
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential signed 4x4 radix-2 Booth multiplier built around the 4-bit add/sub.
module booth_multiplier_seq
    import booth_multiplier_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    booth_multiplier_seq_if.slave  bus
);

    state_t                state_r;
    state_t                next_state_s;
    logic [OP_WIDTH-1:0]   acc_r;
    logic [OP_WIDTH-1:0]   q_r;
    logic [OP_WIDTH-1:0]   m_r;
    logic                  q_1_r;
    logic [1:0]            count_r;
    logic [PROD_WIDTH-1:0] product_r;

    logic [OP_WIDTH-1:0]   sum_s;
    logic                  overflow_s;
    logic                  sub_s;
    logic [OP_WIDTH-1:0]   s_s;
    logic                  sign_s;
    logic [OP_WIDTH-1:0]   acc_next_s;
    logic [OP_WIDTH-1:0]   q_next_s;
    logic                  last_iter_s;

    assign sub_s       = q_r[0] & ~q_1_r;
    assign last_iter_s = (count_r == 2'(ITERATIONS - 1));

    adder_subtractor u_addsub (
        .a        (acc_r),
        .b        (m_r),
        .k        (sub_s),
        .sum      (sum_s),
        .overflow (overflow_s)
    );

    // One Booth step: pick acc or acc+/-m, recover its true sign (the sum can
    // need a fifth bit when m = -8), then arithmetic-shift {acc,q,q_1} right.
    always_comb begin
        s_s    = acc_r;
        sign_s = acc_r[OP_WIDTH-1];
        if (booth_uses_addsub(q_r[0], q_1_r)) begin
            s_s    = sum_s;
            sign_s = sum_s[OP_WIDTH-1] ^ overflow_s;
        end else begin
            s_s    = acc_r;
            sign_s = acc_r[OP_WIDTH-1];
        end
        acc_next_s = {sign_s, s_s[OP_WIDTH-1:1]};
        q_next_s   = {s_s[0], q_r[OP_WIDTH-1:1]};
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: start is honoured only in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    next_state_s = ST_CALC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_iter_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CALC;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Operand capture, iteration registers and the held product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= 4'd0;
            q_r       <= 4'd0;
            m_r       <= 4'd0;
            q_1_r     <= 1'b0;
            count_r   <= 2'd0;
            product_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        m_r     <= bus.multiplicand;
                        q_r     <= bus.multiplier;
                        acc_r   <= 4'd0;
                        q_1_r   <= 1'b0;
                        count_r <= 2'd0;
                    end
                end
                ST_CALC: begin
                    acc_r   <= acc_next_s;
                    q_r     <= q_next_s;
                    q_1_r   <= q_r[0];
                    count_r <= count_r + 2'd1;
                    if (last_iter_s) begin
                        product_r <= {acc_next_s, q_next_s};
                    end
                end
                ST_DONE: begin
                    count_r <= count_r;
                end
                default: begin
                    count_r <= 2'd0;
                end
            endcase
        end
    end

    assign bus.busy    = (state_r == ST_CALC);
    assign bus.done    = (state_r == ST_DONE);
    assign bus.product = product_r;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed and exhaustive self-checking bench for booth_multiplier_seq.
module tb_booth_multiplier_seq;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic [7:0] exp_q[$];

    booth_multiplier_seq_if bus ();

    booth_multiplier_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then follow busy/done and score the product.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] e, input string tag);
        int         busy_cnt;
        bit         seen;
        logic [7:0] exp;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt  = 0;
        seen      = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_product"}, 32'(bus.product), 32'(exp));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int         done_cnt;
        int         t_first;
        int         t_second;
        int         pa;
        int         pb;
        logic [7:0] exp;
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = 4'd0;
        bus.multiplier   = 4'd0;

        // Reset applied away from any clock edge must act immediately.
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_product", 32'(bus.product), 32'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd3, 4'd2, 8'h06, "basic_3x2");
        run_op(4'hD, 4'd5, 8'hF1, "mixed_m3x5");
        run_op(4'h8, 4'h8, 8'h40, "neg8xneg8");
        run_op(4'd7, 4'h8, 8'hC8, "7xneg8");

        // Start re-pulsed in CALC and in DONE must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 4'd2;
        bus.multiplier   = 4'd3;
        exp_q.push_back(8'h06);
        done_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("hs_product", 32'(bus.product), 32'(exp));
            end
            bus.start = (i == 2) || bus.done;
            if (i == 2) begin
                bus.multiplicand = 4'd7;
                bus.multiplier   = 4'd7;
            end
        end
        bus.start = 1'b0;
        check("hs_done_count", 32'(done_cnt), 32'd1);
        check("hs_no_restart", 32'(bus.busy), 32'd0);
        check("hs_product_held", 32'(bus.product), 32'h06);

        // Held start: second operation accepted on the first IDLE edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 4'd3;
        bus.multiplier   = 4'd3;
        exp_q.push_back(8'h09);
        t_first  = -1;
        t_second = -1;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t == 1) begin
                bus.multiplicand = 4'hE;
                bus.multiplier   = 4'd5;
                exp_q.push_back(8'hF6);
            end
            if (bus.done) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("held_product", 32'(bus.product), 32'(exp));
                if (t_first < 0) begin
                    t_first = t;
                end else if (t_second < 0) begin
                    t_second = t;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        check("held_first_done", 32'(t_first), 32'd5);
        check("held_spacing", 32'(t_second - t_first), 32'd6);
        check("held_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the second CALC cycle discards the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 4'd5;
        bus.multiplier   = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_product", 32'(bus.product), 32'h00);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        check("midrst_idle", 32'(bus.busy), 32'd0);

        // Exhaustive sweep against a signed reference.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                pa = (ia > 7) ? ia - 16 : ia;
                pb = (ib > 7) ? ib - 16 : ib;
                run_op(4'(ia), 4'(ib), 8'(pa * pb), "sweep");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
- Sequential signed 4x4 radix-2 Booth multiplier with an 8-bit signed product.
- Sits directly upstream of the 4-bit add/sub datapath: drives its A, B and K inputs each iteration, then consumes its sum and overflow outputs.
- Operates on one operand pair at a time using a start/busy/done handshake.
- Serves as the arithmetic-unit stage that turns the combinational add/sub into a multiply.

Parameters:
- None. Width is fixed at 4 by the add/sub datapath; iteration count is fixed at 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- multiplicand  input  4  signed operand M, two's complement
- multiplier  input  4  signed operand Q, two's complement
- busy  output  1  high while iterating (CALC)
- done  output  1  one-cycle completion pulse
- product  output  8  signed result; holds the last completed value

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst_n is asynchronous and active-low.
  - Reset values: state=IDLE, acc=0, q=0, q_1=0, m=0, count=0, product=8'h00, busy=0, done=0.
- States: IDLE, CALC, DONE.
  - IDLE with start=1 at edge N: m<=multiplicand, q<=multiplier, acc<=0, q_1<=0, count<=0, go to CALC.
  - IDLE with start=0: stay in IDLE; registers hold.
  - CALC: one Booth iteration per edge (edges N+1..N+4), count increments each edge.
    - On the 4th iteration (count==3): product<={acc_next,q_next}, go to DONE.
  - DONE: go to IDLE on the next edge.
- Outputs: busy=(state==CALC); done=(state==DONE). Both are decoded from registered state.
- Latency: start sampled at edge N gives done high for exactly the cycle between edges N+4 and N+5.
  - product updates at edge N+4 and holds until the next completion.
- Datapath drive (combinational, every cycle):
  - Add/sub A=acc, B=m, K=(q[0]==1 && q_1==0).
- Booth pair {q[0],q_1}:
  - 01: s = sum, i.e. acc+m.
  - 10: s = sum with K=1, i.e. acc-m.
  - 00 or 11: s = acc; the add/sub output is ignored.
- Sign and shift:
  - True sign of s: sign = sum[3]^overflow when an add/sub is used; acc[3] otherwise.
  - This handles the 5-bit excursion when m = -8.
  - Arithmetic shift right: acc<={sign,s[3:1]}; q<={s[0],q[3:1]}; q_1<=q[0].
- Result range: product is exact for all 256 operand pairs; the range is -56..+64, and +64 = 8'h40 fits.
- start while busy or in DONE: ignored. No queueing and no restart.
- Operands are captured at start; input changes during CALC have no effect.
- Reset asserted mid-operation: immediate return to reset values; the partial result is discarded; done does not pulse.
- Held start (start=1 continuously): a new operation is accepted on the first IDLE edge, i.e. one operation every 6 cycles.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2
  - constants OP_WIDTH=4, ITERATIONS=4
- One sub-module: instantiate the existing 4-bit adder_subtractor as the iteration datapath; no new arithmetic module.
- FSM and shift registers stay in booth_multiplier_seq.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with no clock edge -> busy=0, done=0, product=8'h00 immediately.
- Basic multiply: M=3, Q=2, pulse start -> busy high 4 cycles, done 1 cycle later, product=8'h06.
- Mixed signs: M=-3 (4'hD), Q=5 -> product=8'hF1 (-15).
- Most-negative operand, two cases:
  - M=-8, Q=-8 -> product=8'h40 (+64).
  - M=7, Q=-8 -> product=8'hC8 (-56).
- Handshake robustness: pulse start with M=2, Q=3.
  - Re-pulse start with M=7, Q=7 in CALC and again in DONE -> both ignored; product=8'h06; exactly one done pulse.
  - Hold start high -> next operation accepted on the first IDLE edge.
- Reset mid-operation, then exhaustive check:
  - Drop rst_n during the 2nd CALC cycle -> returns to IDLE, product=8'h00, no done pulse.
  - After release, sweep all 256 pairs against a signed reference model.
